// File: rtl/ps2_keymatrix.sv
// PS/2 keyboard to row/column key matrix: decodes scancode frames into a held-key matrix read by active-low row select.
// Latency: frame reported 1 cycle after its last bit shifts in; matrix, resetk and tapek update 1 cycle after that.
// Backpressure: none; sc_valid/perr are single-cycle strobes that are never held off by the consumer.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   kclk, kdat        raw asynchronous PS/2 clock and data lines
//   a                 row select, active-low; several rows may be selected at once
//   row               column data, active-low, AND of every selected row
//   resetk, tapek     levels that are high while ESC / F1 are held
//   sc_valid, sc_data strobe plus scancode byte of the last good frame
//   perr              strobe for a frame with bad parity or a missing stop bit
module ps2_keymatrix #(
  parameter int NROWS     = 8,
  parameter int NCOLS     = 5,
  parameter int TOUT_BITS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kclk,
  input  logic             kdat,
  input  logic [NROWS-1:0] a,
  output logic [NCOLS-1:0] row,
  output logic             resetk,
  output logic             tapek,
  output logic             sc_valid,
  output logic [7:0]       sc_data,
  output logic             perr
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_REL     = 2'd2;
  localparam logic [1:0] ST_EXT_REL = 2'd3;

  // The map only defines five columns; wider parameters leave extra columns idle.
  localparam int NC = (NCOLS < 5) ? NCOLS : 5;

  // Compound-key flag positions in comp_q.
  localparam int C_UP    = 0;
  localparam int C_DOWN  = 1;
  localparam int C_LEFT  = 2;
  localparam int C_RIGHT = 3;
  localparam int C_BKSP  = 4;

  // Returns {hit, row[2:0], col[2:0]} for a scancode.
  function automatic logic [6:0] key_map(input logic ext, input logic [7:0] code);
    logic [6:0] m;
    m = 7'd0;
    if (ext) begin
      case (code)
        8'h14:   m = {1'b1, 3'd7, 3'd1};
        8'h5A:   m = {1'b1, 3'd6, 3'd0};
        default: m = 7'd0;
      endcase
    end else begin
      case (code)
        8'h12, 8'h59: m = {1'b1, 3'd0, 3'd0};
        8'h1A: m = {1'b1, 3'd0, 3'd1};
        8'h22: m = {1'b1, 3'd0, 3'd2};
        8'h21: m = {1'b1, 3'd0, 3'd3};
        8'h2A: m = {1'b1, 3'd0, 3'd4};
        8'h1C: m = {1'b1, 3'd1, 3'd0};
        8'h1B: m = {1'b1, 3'd1, 3'd1};
        8'h23: m = {1'b1, 3'd1, 3'd2};
        8'h2B: m = {1'b1, 3'd1, 3'd3};
        8'h34: m = {1'b1, 3'd1, 3'd4};
        8'h15: m = {1'b1, 3'd2, 3'd0};
        8'h1D: m = {1'b1, 3'd2, 3'd1};
        8'h24: m = {1'b1, 3'd2, 3'd2};
        8'h2D: m = {1'b1, 3'd2, 3'd3};
        8'h2C: m = {1'b1, 3'd2, 3'd4};
        8'h16: m = {1'b1, 3'd3, 3'd0};
        8'h1E: m = {1'b1, 3'd3, 3'd1};
        8'h26: m = {1'b1, 3'd3, 3'd2};
        8'h25: m = {1'b1, 3'd3, 3'd3};
        8'h2E: m = {1'b1, 3'd3, 3'd4};
        8'h45: m = {1'b1, 3'd4, 3'd0};
        8'h46: m = {1'b1, 3'd4, 3'd1};
        8'h3E: m = {1'b1, 3'd4, 3'd2};
        8'h3D: m = {1'b1, 3'd4, 3'd3};
        8'h36: m = {1'b1, 3'd4, 3'd4};
        8'h4D: m = {1'b1, 3'd5, 3'd0};
        8'h44: m = {1'b1, 3'd5, 3'd1};
        8'h43: m = {1'b1, 3'd5, 3'd2};
        8'h3C: m = {1'b1, 3'd5, 3'd3};
        8'h35: m = {1'b1, 3'd5, 3'd4};
        8'h5A: m = {1'b1, 3'd6, 3'd0};
        8'h4B: m = {1'b1, 3'd6, 3'd1};
        8'h42: m = {1'b1, 3'd6, 3'd2};
        8'h3B: m = {1'b1, 3'd6, 3'd3};
        8'h33: m = {1'b1, 3'd6, 3'd4};
        8'h29: m = {1'b1, 3'd7, 3'd0};
        8'h14: m = {1'b1, 3'd7, 3'd1};
        8'h3A: m = {1'b1, 3'd7, 3'd2};
        8'h31: m = {1'b1, 3'd7, 3'd3};
        8'h32: m = {1'b1, 3'd7, 3'd4};
        default: m = 7'd0;
      endcase
    end
    return m;
  endfunction

  // Line synchronizers and frame receiver state.
  logic                 kclk_meta_q, kclk_sync_q, kclk_old_q;
  logic                 kdat_meta_q, kdat_sync_q;
  logic [10:0]          sr_q, sr_d;
  logic [TOUT_BITS-1:0] tout_q, tout_d;
  logic                 sc_valid_q, sc_valid_d;
  logic                 perr_q, perr_d;
  logic [7:0]           sc_data_q, sc_data_d;

  // Decoder and key state.
  logic [1:0]           state_q, state_d;
  logic [7:0][4:0]      phys_q, phys_d;
  logic [4:0]           comp_q, comp_d;
  logic                 resetk_q, resetk_d;
  logic                 tapek_q, tapek_d;

  logic fall, frame_done, frame_ok, tout_max;

  assign fall       = kclk_old_q & ~kclk_sync_q;
  // The shift register starts as all ones, so the start bit is the first 0 to reach bit 0.
  assign frame_done = ~sr_q[0];
  assign frame_ok   = frame_done & sr_q[10] & (^sr_q[9:1]);
  assign tout_max   = &tout_q;

  always_comb begin
    sr_d = sr_q;
    if (fall) begin
      // A falling edge in the completion cycle starts the next frame on a fresh register.
      sr_d = {kdat_sync_q, (frame_done ? 10'h3FF : sr_q[10:1])};
    end else if (frame_done || tout_max) begin
      sr_d = '1;
    end
    tout_d     = fall ? '0 : tout_q + 1'b1;
    sc_valid_d = frame_ok;
    perr_d     = frame_done & ~frame_ok;
    sc_data_d  = frame_ok ? sr_q[8:1] : sc_data_q;
  end

  // Prefix tracking: decides whether the current byte is a prefix, a global release or a key event.
  logic ev, ev_ext, ev_rel, clr_all;

  always_comb begin
    state_d = state_q;
    ev      = 1'b0;
    ev_ext  = 1'b0;
    ev_rel  = 1'b0;
    clr_all = 1'b0;
    if (perr_q) begin
      state_d = ST_IDLE;
    end else if (sc_valid_q) begin
      case (state_q)
        ST_IDLE: begin
          if (sc_data_q == 8'hE0) begin
            state_d = ST_EXT;
          end else if (sc_data_q == 8'hF0) begin
            state_d = ST_REL;
          end else if (sc_data_q == 8'hAA || sc_data_q == 8'hFC ||
                       sc_data_q == 8'h00 || sc_data_q == 8'hFF) begin
            clr_all = 1'b1;
          end else begin
            ev = 1'b1;
          end
        end
        ST_EXT: begin
          if (sc_data_q == 8'hF0) begin
            state_d = ST_EXT_REL;
          end else begin
            ev      = 1'b1;
            ev_ext  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_REL: begin
          ev      = 1'b1;
          ev_rel  = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          ev      = 1'b1;
          ev_ext  = 1'b1;
          ev_rel  = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  logic [6:0] km;
  logic [2:0] km_r, km_c;

  assign km   = key_map(ev_ext, sc_data_q);
  assign km_r = km[5:3];
  assign km_c = km[2:0];

  always_comb begin
    phys_d   = phys_q;
    comp_d   = comp_q;
    resetk_d = resetk_q;
    tapek_d  = tapek_q;
    if (clr_all) begin
      phys_d   = '0;
      comp_d   = '0;
      resetk_d = 1'b0;
      tapek_d  = 1'b0;
    end else if (ev) begin
      // Keys outside the configured matrix are dropped rather than aliased.
      if (km[6] && ({1'b0, km_r} < 4'(NROWS)) && ({1'b0, km_c} < 4'(NC))) begin
        phys_d[km_r][km_c] = ~ev_rel;
      end
      if (ev_ext) begin
        case (sc_data_q)
          8'h75:   comp_d[C_UP]    = ~ev_rel;
          8'h72:   comp_d[C_DOWN]  = ~ev_rel;
          8'h6B:   comp_d[C_LEFT]  = ~ev_rel;
          8'h74:   comp_d[C_RIGHT] = ~ev_rel;
          default: ;
        endcase
      end else begin
        case (sc_data_q)
          8'h66:   comp_d[C_BKSP] = ~ev_rel;
          8'h76:   resetk_d       = ~ev_rel;
          8'h05:   tapek_d        = ~ev_rel;
          default: ;
        endcase
      end
    end
  end

  // Effective matrix: compound flags are OR-ed in, so releasing an arrow never
  // clears a physically held CAPS SHIFT or digit.
  logic [7:0][4:0] eff;

  always_comb begin
    eff = phys_q;
    if (|comp_q)         eff[0][0] = 1'b1;  // CAPS SHIFT
    if (comp_q[C_UP])    eff[4][3] = 1'b1;  // 7
    if (comp_q[C_DOWN])  eff[4][4] = 1'b1;  // 6
    if (comp_q[C_LEFT])  eff[3][4] = 1'b1;  // 5
    if (comp_q[C_RIGHT]) eff[4][2] = 1'b1;  // 8
    if (comp_q[C_BKSP])  eff[4][0] = 1'b1;  // 0
  end

  always_comb begin
    row = '1;
    for (int r = 0; r < NROWS; r++) begin
      if (!a[r]) begin
        for (int c = 0; c < NC; c++) begin
          if (eff[r][c]) row[c] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_meta_q <= 1'b1;
      kclk_sync_q <= 1'b1;
      kclk_old_q  <= 1'b1;
      kdat_meta_q <= 1'b1;
      kdat_sync_q <= 1'b1;
      sr_q        <= '1;
      tout_q      <= '0;
      sc_valid_q  <= 1'b0;
      perr_q      <= 1'b0;
      sc_data_q   <= 8'h00;
      state_q     <= ST_IDLE;
      phys_q      <= '0;
      comp_q      <= '0;
      resetk_q    <= 1'b0;
      tapek_q     <= 1'b0;
    end else begin
      kclk_meta_q <= kclk;
      kclk_sync_q <= kclk_meta_q;
      kclk_old_q  <= kclk_sync_q;
      kdat_meta_q <= kdat;
      kdat_sync_q <= kdat_meta_q;
      sr_q        <= sr_d;
      tout_q      <= tout_d;
      sc_valid_q  <= sc_valid_d;
      perr_q      <= perr_d;
      sc_data_q   <= sc_data_d;
      state_q     <= state_d;
      phys_q      <= phys_d;
      comp_q      <= comp_d;
      resetk_q    <= resetk_d;
      tapek_q     <= tapek_d;
    end
  end

  assign resetk   = resetk_q;
  assign tapek    = tapek_q;
  assign sc_valid = sc_valid_q;
  assign sc_data  = sc_data_q;
  assign perr     = perr_q;

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Self-checking bench for ps2_keymatrix: directed scenarios plus random key traffic against a key-level model.
// Latency: each PS/2 frame takes about 100 clk cycles including settle time.
// Backpressure: not applicable; the bench drives raw PS/2 lines and row selects.
module tb_ps2_keymatrix;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  = 1'b1;
  logic       kclk = 1'b1;
  logic       kdat = 1'b1;
  logic [7:0] a    = 8'hFF;
  logic [3:0] a4   = 4'hF;
  logic [4:0] row, row4;
  logic       resetk, tapek, sc_valid, perr;
  logic       resetk4, tapek4, sc_valid4, perr4;
  logic [7:0] sc_data, sc_data4;

  ps2_keymatrix dut (
    .clk(clk), .rst(rst), .kclk(kclk), .kdat(kdat), .a(a), .row(row),
    .resetk(resetk), .tapek(tapek), .sc_valid(sc_valid), .sc_data(sc_data), .perr(perr)
  );

  ps2_keymatrix #(.NROWS(4)) dut4 (
    .clk(clk), .rst(rst), .kclk(kclk), .kdat(kdat), .a(a4), .row(row4),
    .resetk(resetk4), .tapek(tapek4), .sc_valid(sc_valid4), .sc_data(sc_data4), .perr(perr4)
  );

  int nchk  = 0;
  int nfail = 0;

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model (key level) ----------------
  // Positions are row*5+col in the full 8x5 map.
  byte unsigned kmap [40] = '{
    8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
    8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
    8'h29, 8'h14, 8'h3A, 8'h31, 8'h32 };
  // Compound keys: up, down, left, right (extended) and backspace (plain), with the digit each adds.
  byte unsigned comp_code [5] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h66};
  int           comp_pos  [5] = '{23, 24, 19, 22, 20};
  // Extra keys for random traffic: aliases, extended keys, compounds, ESC/F1 and unmapped codes.
  byte unsigned xcode [13] = '{8'h59, 8'h14, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74,
                               8'h66, 8'h76, 8'h05, 8'h0D, 8'h1C, 8'h70};
  bit           xext  [13] = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
  byte unsigned rcodes [4] = '{8'hAA, 8'hFC, 8'h00, 8'hFF};

  bit       mphys [40];
  bit       mcomp [5];
  bit       mresetk, mtapek;
  logic [7:0] exp_data = 8'h00;
  int       evcnt = 0, epcnt = 0;
  int       vcnt = 0, pcnt = 0, vcnt4 = 0, pcnt4 = 0;
  bit       stable = 1'b0;
  bit       rand_a = 1'b0;
  logic [7:0] a_fix  = 8'h00;
  logic [3:0] a4_fix = 4'h0;

  function automatic int map_pos(bit ext, byte unsigned code);
    if (ext && code != 8'h14 && code != 8'h5A) return -1;
    if (!ext && code == 8'h59) return 0;
    for (int i = 0; i < 40; i++) if (kmap[i] == code) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 40; i++) mphys[i] = 1'b0;
    for (int k = 0; k < 5; k++) mcomp[k] = 1'b0;
    mresetk = 1'b0;
    mtapek  = 1'b0;
  endtask

  task automatic model_key(bit ext, bit rel, byte unsigned code);
    int p;
    p = map_pos(ext, code);
    if (p >= 0) mphys[p] = !rel;
    for (int k = 0; k < 5; k++)
      if (code == comp_code[k] && ext == (k < 4)) mcomp[k] = !rel;
    if (!ext && code == 8'h76) mresetk = !rel;
    if (!ext && code == 8'h05) mtapek = !rel;
  endtask

  function automatic bit pressed(int idx);
    bit p;
    p = mphys[idx];
    for (int k = 0; k < 5; k++)
      if (mcomp[k] && (idx == 0 || idx == comp_pos[k])) p = 1'b1;
    return p;
  endfunction

  function automatic logic [4:0] exp_row(int nr, logic [7:0] sel);
    logic [4:0] v;
    v = 5'h1F;
    for (int r = 0; r < nr; r++)
      if (!sel[r])
        for (int c = 0; c < 5; c++)
          if (pressed(r * 5 + c)) v[c] = 1'b0;
    return v;
  endfunction

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (sc_valid)  vcnt++;
    if (perr)      pcnt++;
    if (sc_valid4) vcnt4++;
    if (perr4)     pcnt4++;
    if (stable) begin
      check("row", row, exp_row(8, a));
      check("row_n4", row4, exp_row(4, {4'hF, a4}));
      check("resetk", resetk, mresetk);
      check("tapek", tapek, mtapek);
      check("resetk_n4", resetk4, mresetk);
      check("tapek_n4", tapek4, mtapek);
    end
    if (rand_a) begin
      a  = 8'($urandom);
      a4 = 4'($urandom);
    end else begin
      a  = a_fix;
      a4 = a4_fix;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(bit b);
    kdat = b;
    tick(3);
    kclk = 1'b0;
    tick(4);
    kclk = 1'b1;
    tick(1);
  endtask

  // kind: 0 good, 1 parity flipped, 2 stop bit 0
  task automatic send_frame(logic [7:0] b, int kind);
    bit par;
    par = ~^b;
    if (kind == 1) par = ~par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(kind == 2 ? 1'b0 : 1'b1);
    tick(8);
    if (kind == 0) begin
      evcnt++;
      exp_data = b;
    end else begin
      epcnt++;
    end
    check("sc_valid_count", vcnt, evcnt);
    check("perr_count", pcnt, epcnt);
    check("sc_data", sc_data, exp_data);
    check("sc_valid_count_n4", vcnt4, evcnt);
    check("perr_count_n4", pcnt4, epcnt);
    check("sc_data_n4", sc_data4, exp_data);
  endtask

  task automatic key_event(bit ext, bit rel, byte unsigned code);
    stable = 1'b0;
    if (ext) send_frame(8'hE0, 0);
    if (rel) send_frame(8'hF0, 0);
    send_frame(code, 0);
    model_key(ext, rel, code);
    stable = 1'b1;
  endtask

  task automatic reset_code(byte unsigned code);
    stable = 1'b0;
    send_frame(code, 0);
    model_clear();
    stable = 1'b1;
  endtask

  task automatic set_sel(logic [7:0] s, logic [3:0] s4);
    a_fix  = s;
    a4_fix = s4;
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    int act, pick;
    bit ext, rel;
    byte unsigned code;

    model_clear();
    // Reset state, held with all rows selected.
    rst = 1'b1;
    tick(6);
    check("rst_row", row, 5'h1F);
    check("rst_row_n4", row4, 5'h1F);
    check("rst_resetk", resetk, 1'b0);
    check("rst_tapek", tapek, 1'b0);
    check("rst_sc_valid", sc_valid, 1'b0);
    check("rst_perr", perr, 1'b0);
    check("rst_sc_data", sc_data, 8'h00);
    rst = 1'b0;
    tick(2);
    stable = 1'b1;

    // Press A (typematic repeat), read row 1, release.
    key_event(0, 0, 8'h1C);
    key_event(0, 0, 8'h1C);
    set_sel(8'hFD, 4'hD);
    check("lit_a_pressed", row, 5'b11110);
    check("lit_a_pressed_n4", row4, 5'b11110);
    key_event(0, 1, 8'h1C);
    check("lit_a_released", row, 5'b11111);

    // Bad parity frame aborts nothing held and leaves the decoder in IDLE.
    key_event(0, 0, 8'h1B);
    check("lit_s_pressed", row, 5'b11101);
    send_frame(8'h1C, 1);
    check("lit_after_perr", row, 5'b11101);
    key_event(0, 1, 8'h1B);
    check("lit_s_released", row, 5'b11111);
    key_event(0, 1, 8'h2B);  // release of a key never pressed

    // Shift plus up arrow; arrow release keeps the physical shift.
    key_event(0, 0, 8'h12);
    key_event(1, 0, 8'h75);
    set_sel(8'hFE, 4'hE);
    check("lit_caps_row0", row, 5'b11110);
    set_sel(8'hEF, 4'hF);
    check("lit_up_row4", row, 5'b10111);
    key_event(1, 1, 8'h75);
    check("lit_up_rel_row4", row, 5'b11111);
    set_sel(8'hFE, 4'hE);
    check("lit_caps_held", row, 5'b11110);
    key_event(0, 1, 8'h12);
    check("lit_caps_rel", row, 5'b11111);

    // ESC / F1 levels and global release.
    key_event(0, 0, 8'h76);
    key_event(0, 0, 8'h05);
    key_event(0, 0, 8'h1C);
    check("lit_resetk_on", resetk, 1'b1);
    check("lit_tapek_on", tapek, 1'b1);
    reset_code(8'hAA);
    set_sel(8'h00, 4'h0);
    check("lit_resetk_off", resetk, 1'b0);
    check("lit_tapek_off", tapek, 1'b0);
    check("lit_all_released", row, 5'b11111);

    // Partial frame abandoned by the inactivity timeout.
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    tick(4096 + 16);
    key_event(0, 0, 8'h29);
    check("lit_timeout_code", sc_data, 8'h29);
    set_sel(8'h7F, 4'h0);
    check("lit_timeout_row7", row, 5'b11110);
    check("lit_n4_ignores_row7", row4, 5'b11111);
    key_event(0, 1, 8'h29);

    // Random traffic with random row selection every cycle.
    rand_a = 1'b1;
    for (int n = 0; n < 120; n++) begin
      act = $urandom_range(0, 99);
      if (act < 72) begin
        if ($urandom_range(0, 99) < 55) begin
          ext  = 1'b0;
          code = kmap[$urandom_range(0, 39)];
        end else begin
          pick = $urandom_range(0, 12);
          ext  = xext[pick];
          code = xcode[pick];
        end
        rel = ($urandom_range(0, 99) < 40);
        key_event(ext, rel, code);
      end else if (act < 78) begin
        reset_code(rcodes[$urandom_range(0, 3)]);
      end else if (act < 89) begin
        send_frame(8'($urandom), $urandom_range(1, 2));
      end else begin
        send_frame(($urandom_range(0, 1) != 0) ? 8'hE0 : 8'hF0, 0);
        send_frame(8'($urandom), $urandom_range(1, 2));
      end
    end
    rand_a = 1'b0;

    // Reset in the middle of an extended sequence and a partial frame.
    key_event(0, 0, 8'h76);
    key_event(0, 0, 8'h1B);
    stable = 1'b0;
    send_frame(8'hE0, 0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    set_sel(8'h00, 4'h0);
    rst = 1'b1;
    tick(3);
    model_clear();
    exp_data = 8'h00;
    check("midrst_row", row, 5'h1F);
    check("midrst_resetk", resetk, 1'b0);
    check("midrst_sc_data", sc_data, 8'h00);
    rst = 1'b0;
    tick(2);
    stable = 1'b1;
    key_event(0, 0, 8'h1C);
    set_sel(8'hFD, 4'hD);
    check("lit_after_rst", row, 5'b11110);
    check("lit_after_rst_code", sc_data, 8'h1C);

    tick(4);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
